// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory boot loader:
// FSM state encoding, word geometry and the address step.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_CHK    = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_t;

  localparam int          BYTES_PER_WORD = 4;
  localparam logic [1:0]  LAST_BYTE_IDX  = 2'(BYTES_PER_WORD - 1);
  // Same increment the Sumador applies to the PC, so fetch walks the
  // words in exactly the order they were written.
  localparam logic [31:0] ADDR_STEP      = 32'd4;

  // Next word address; 32-bit modulo arithmetic is intended.
  function automatic logic [31:0] next_addr(input logic [31:0] addr);
    return addr + ADDR_STEP;
  endfunction

endpackage

// File: rtl/inst_mem_loader_if.sv
// Byte-stream input, instruction-memory write port and status of the loader.
//
// Handshake: a byte moves on a rising edge where ByteValid && ByteReady are
// both high. The source may raise ByteValid at any time and must hold ByteIn
// stable while ByteValid is high and the byte has not been taken; ByteReady
// never depends on ByteValid in the same cycle (it is a registered decode).
interface inst_mem_loader_if;

  logic        Start;
  logic [7:0]  ByteIn;
  logic        ByteValid;
  logic        ByteReady;
  logic        MI_Write;
  logic [31:0] MI_Dir;
  logic [31:0] MI_Dato;
  logic        CPU_Hold;
  logic        Done;
  logic        Error;
  logic [15:0] WordCount;

  // The loader side.
  modport master (
    input  Start, ByteIn, ByteValid,
    output ByteReady, MI_Write, MI_Dir, MI_Dato,
    output CPU_Hold, Done, Error, WordCount
  );

  // The stream source / memory / core side.
  modport slave (
    output Start, ByteIn, ByteValid,
    input  ByteReady, MI_Write, MI_Dir, MI_Dato,
    input  CPU_Hold, Done, Error, WordCount
  );

endinterface

// File: rtl/word_packer.sv
// Packs accepted payload bytes MSB-first into 32-bit words and keeps the
// running XOR checksum. word_done_o/word_next_o are combinational so the
// caller can register the finished word on the same edge as the 4th byte.
module word_packer
  import loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        clear_i,
  input  logic        accept_i,
  input  logic [7:0]  byte_i,
  output logic        word_done_o,
  output logic [31:0] word_next_o,
  output logic [7:0]  csum_o
);

  logic [1:0]  idx_q;
  logic [23:0] asm_q;
  logic [7:0]  csum_q;

  assign word_done_o = accept_i && (idx_q == LAST_BYTE_IDX);
  assign word_next_o = {asm_q, byte_i};
  assign csum_o      = csum_q;

  // Byte index, upper three bytes of the word under assembly, checksum.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i || clear_i) begin
      idx_q  <= '0;
      asm_q  <= '0;
      csum_q <= '0;
    end else if (accept_i) begin
      idx_q  <= idx_q + 2'd1;
      asm_q  <= {asm_q[15:0], byte_i};
      csum_q <= csum_q ^ byte_i;
    end
  end

endmodule

// File: rtl/inst_mem_loader.sv
// Boot-time instruction-memory writer: parses a length-prefixed byte stream,
// writes each big-endian word through the MemInst write port while holding
// the core, and releases the core only after the checksum matches.
module inst_mem_loader
  import loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 256
) (
  input  logic              CLK,
  input  logic              RST_N,
  inst_mem_loader_if.master bus,
  output state_t            dbg_state_o
);

  state_t      state_q;
  logic        byte_ready_q;
  logic        mi_write_q;
  logic [31:0] mi_dir_q;
  logic [31:0] mi_dato_q;
  logic        hold_q;
  logic        done_q;
  logic        error_q;
  logic [15:0] wcount_q;
  logic [15:0] words_rem_q;

  logic        accept;
  logic        data_accept;
  logic        start_ok;
  logic [15:0] len_full;
  logic        word_done;
  logic [31:0] word_next;
  logic [7:0]  csum;

  assign accept      = bus.ByteValid && byte_ready_q;
  assign data_accept = accept && (state_q == ST_DATA);
  assign start_ok    = bus.Start &&
                       ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                        (state_q == ST_ERR));
  assign len_full    = {wcount_q[15:8], bus.ByteIn};

  word_packer u_packer (
    .clk_i       (CLK),
    .rst_n_i     (RST_N),
    .clear_i     (start_ok),
    .accept_i    (data_accept),
    .byte_i      (bus.ByteIn),
    .word_done_o (word_done),
    .word_next_o (word_next),
    .csum_o      (csum)
  );

  // Loader FSM with registered outputs, address counter and core hold.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q      <= ST_IDLE;
      byte_ready_q <= 1'b0;
      mi_write_q   <= 1'b0;
      mi_dir_q     <= BASE_ADDR;
      mi_dato_q    <= '0;
      hold_q       <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      wcount_q     <= '0;
      words_rem_q  <= '0;
    end else begin
      mi_write_q <= 1'b0;
      // Address moves on only after the strobe has used it.
      if (mi_write_q) begin
        mi_dir_q <= next_addr(mi_dir_q);
      end
      // A finished word is strobed in the cycle after its 4th byte; this also
      // covers the last word, whose strobe lands while already in CHK.
      if (word_done) begin
        mi_write_q <= 1'b1;
        mi_dato_q  <= word_next;
      end

      case (state_q)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start_ok) begin
            state_q      <= ST_LEN_HI;
            byte_ready_q <= 1'b1;
            hold_q       <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            mi_dir_q     <= BASE_ADDR;
          end
        end
        ST_LEN_HI: begin
          if (accept) begin
            wcount_q[15:8] <= bus.ByteIn;
            state_q        <= ST_LEN_LO;
          end
        end
        ST_LEN_LO: begin
          if (accept) begin
            wcount_q[7:0] <= bus.ByteIn;
            words_rem_q   <= len_full;
            if ({16'd0, len_full} > 32'(MAX_WORDS)) begin
              state_q      <= ST_ERR;
              byte_ready_q <= 1'b0;
              error_q      <= 1'b1;
            end else if (len_full == 16'd0) begin
              state_q <= ST_CHK;
            end else begin
              state_q <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (word_done) begin
            words_rem_q <= words_rem_q - 16'd1;
            if (words_rem_q == 16'd1) begin
              state_q <= ST_CHK;
            end
          end
        end
        ST_CHK: begin
          if (accept) begin
            byte_ready_q <= 1'b0;
            if (bus.ByteIn == csum) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              hold_q  <= 1'b0;
            end else begin
              state_q <= ST_ERR;
              error_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          byte_ready_q <= 1'b0;
          hold_q       <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ByteReady = byte_ready_q;
  assign bus.MI_Write  = mi_write_q;
  assign bus.MI_Dir    = mi_dir_q;
  assign bus.MI_Dato   = mi_dato_q;
  assign bus.CPU_Hold  = hold_q;
  assign bus.Done      = done_q;
  assign bus.Error     = error_q;
  assign bus.WordCount = wcount_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader: streams hand-built images and checks
// the MemInst writes, status outputs and reset behaviour.
module tb_inst_mem_loader;
  import loader_pkg::*;

  logic   clk;
  logic   rst_n;
  state_t dbg_state;

  inst_mem_loader_if bus ();

  inst_mem_loader #(
    .BASE_ADDR (32'h0000_0000),
    .MAX_WORDS (256)
  ) dut (
    .CLK         (clk),
    .RST_N       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int          n_vec;
  int          n_miss;
  logic [63:0] exp_q[$];   // {addr, data} of expected writes
  logic [63:0] obs_q[$];   // {addr, data} of observed writes

  task automatic check_vec(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Write monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (rst_n && bus.MI_Write === 1'b1) begin
      obs_q.push_back({bus.MI_Dir, bus.MI_Dato});
    end
  end

  task automatic compare_writes(input string tag);
    logic [63:0] e;
    logic [63:0] o;
    check_vec({tag, "_nwrites"}, 64'(obs_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      check_vec({tag, "_write"}, o, e);
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one byte and holds it until taken; idle_max inserts random
  // ByteValid-low gaps before the offer.
  task automatic send_byte(input logic [7:0] b, input int idle_max);
    bit got;
    int gap;
    gap = (idle_max > 0) ? $urandom_range(idle_max, 0) : 0;
    bus.ByteValid = 1'b0;
    for (int i = 0; i < gap; i++) tick();
    bus.ByteIn    = b;
    bus.ByteValid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.ByteReady === 1'b1) got = 1'b1;
      tick();
    end
    bus.ByteValid = 1'b0;
    if (!got) check_vec("byte_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic pulse_start();
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
  endtask

  // Streams the length, payload and a checksum (good one, or flipped).
  task automatic send_image(input logic [7:0] pl[], input bit bad_csum);
    logic [7:0]  cs;
    logic [15:0] nw;
    cs = 8'h00;
    nw = 16'(pl.size() / 4);
    send_byte(nw[15:8], 0);
    send_byte(nw[7:0], 0);
    foreach (pl[i]) begin
      send_byte(pl[i], 0);
      cs = cs ^ pl[i];
    end
    for (int w = 0; w < int'(nw); w++) begin
      exp_q.push_back({32'(4 * w), pl[4*w], pl[4*w+1], pl[4*w+2], pl[4*w+3]});
    end
    send_byte(bad_csum ? (cs ^ 8'h01) : cs, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_vec({tag, "_ready"}, 64'(bus.ByteReady), 64'd0);
    check_vec({tag, "_mi_write"}, 64'(bus.MI_Write), 64'd0);
    check_vec({tag, "_mi_dir"}, 64'(bus.MI_Dir), 64'h0);
    check_vec({tag, "_mi_dato"}, 64'(bus.MI_Dato), 64'h0);
    check_vec({tag, "_hold"}, 64'(bus.CPU_Hold), 64'd1);
    check_vec({tag, "_done"}, 64'(bus.Done), 64'd0);
    check_vec({tag, "_error"}, 64'(bus.Error), 64'd0);
    check_vec({tag, "_wcount"}, 64'(bus.WordCount), 64'd0);
    check_vec({tag, "_state"}, 64'(dbg_state), 64'(ST_IDLE));
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] prog[];
  logic [7:0] six[6];

  initial begin
    n_vec = 0;
    n_miss = 0;
    prog = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
    six  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    bus.Start = 1'b0;
    bus.ByteIn = 8'h00;
    bus.ByteValid = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    // 1: reset state
    check_reset_outputs("reset");

    // 2: good two-word image; a byte offered with Start must not be eaten
    bus.ByteIn = 8'hAA;
    bus.ByteValid = 1'b1;
    pulse_start();
    bus.ByteValid = 1'b0;
    check_vec("t2_state_len_hi", 64'(dbg_state), 64'(ST_LEN_HI));
    check_vec("t2_hold_loading", 64'(bus.CPU_Hold), 64'd1);
    send_image(prog, 1'b0);
    check_vec("t2_done", 64'(bus.Done), 64'd1);
    check_vec("t2_hold", 64'(bus.CPU_Hold), 64'd0);
    check_vec("t2_error", 64'(bus.Error), 64'd0);
    check_vec("t2_wcount", 64'(bus.WordCount), 64'd2);
    check_vec("t2_mi_dir_end", 64'(bus.MI_Dir), 64'h8);
    check_vec("t2_ready", 64'(bus.ByteReady), 64'd0);
    compare_writes("t2");

    // 3: same image, wrong checksum, then a good reload
    pulse_start();
    check_vec("t3_hold_restart", 64'(bus.CPU_Hold), 64'd1);
    check_vec("t3_done_cleared", 64'(bus.Done), 64'd0);
    send_image(prog, 1'b1);
    check_vec("t3_error", 64'(bus.Error), 64'd1);
    check_vec("t3_done", 64'(bus.Done), 64'd0);
    check_vec("t3_hold", 64'(bus.CPU_Hold), 64'd1);
    compare_writes("t3");
    pulse_start();
    check_vec("t3_error_cleared", 64'(bus.Error), 64'd0);
    send_image(prog, 1'b0);
    check_vec("t3_reload_done", 64'(bus.Done), 64'd1);
    compare_writes("t3_reload");

    // 4: oversize length 257
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    check_vec("t4_error", 64'(bus.Error), 64'd1);
    check_vec("t4_state", 64'(dbg_state), 64'(ST_ERR));
    check_vec("t4_ready", 64'(bus.ByteReady), 64'd0);
    check_vec("t4_hold", 64'(bus.CPU_Hold), 64'd1);
    check_vec("t4_wcount", 64'(bus.WordCount), 64'h101);
    for (int i = 0; i < 4; i++) tick();
    compare_writes("t4");

    // 5: empty image, good then bad checksum
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    check_vec("t5_state_chk", 64'(dbg_state), 64'(ST_CHK));
    send_byte(8'h00, 0);
    check_vec("t5_done", 64'(bus.Done), 64'd1);
    check_vec("t5_hold", 64'(bus.CPU_Hold), 64'd0);
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'hFF, 0);
    check_vec("t5_error", 64'(bus.Error), 64'd1);
    check_vec("t5_bad_done", 64'(bus.Done), 64'd0);
    compare_writes("t5");

    // 6: gappy stream, ignored Start mid-DATA, reset after 6 payload bytes
    pulse_start();
    send_byte(8'h00, 2);
    send_byte(8'h02, 2);
    for (int i = 0; i < 3; i++) send_byte(six[i], 2);
    pulse_start();
    check_vec("t6_start_ignored", 64'(dbg_state), 64'(ST_DATA));
    check_vec("t6_ready_mid", 64'(bus.ByteReady), 64'd1);
    for (int i = 3; i < 6; i++) send_byte(six[i], 2);
    exp_q.push_back({32'h0, 32'h11223344});
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_reset_outputs("t6_after_rst");
    bus.ByteIn = 8'h77;
    bus.ByteValid = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    bus.ByteValid = 1'b0;
    check_vec("t6_wcount_untouched", 64'(bus.WordCount), 64'd0);
    compare_writes("t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
